// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Provides STATUS bit positions, register offsets and the transmit FSM encoding.
package uart_pkg;

  // STATUS register bit positions
  localparam int unsigned STAT_FULL     = 0;
  localparam int unsigned STAT_EMPTY    = 1;
  localparam int unsigned STAT_BUSY     = 2;
  localparam int unsigned STAT_OVF      = 3;
  localparam int unsigned STAT_COUNT_LO = 4;
  localparam int unsigned STAT_COUNT_HI = 7;

  // Register offsets from BASE_ADDR
  localparam int unsigned TXDATA_OFFSET = 0;
  localparam int unsigned STATUS_OFFSET = 4;

  // Data-bit index width (8 bits per frame)
  localparam int unsigned BIT_IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_port_fifo.sv
// Synchronous byte FIFO with same-edge push and pop.
// Ports:
//   clock, reset        : clock and asynchronous active-high reset
//   push, push_data     : enqueue request and byte (accepted if not full or popping)
//   pop                 : dequeue request (ignored when empty)
//   head_c              : byte at the head, combinational
//   full_c, empty_c     : occupancy flags, combinational from the count
//   count               : registered occupancy, one bit wider than the pointers
module byte_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == '0);
  assign head_c  = mem_q[rd_ptr_q];
  assign count   = count_q;

  // A push into a full FIFO still lands if the head leaves on the same edge
  assign pop_ok  = pop && !empty_c;
  assign push_ok = push && (!full_c || pop_ok);

  // Pointer and count update; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; emptiness is tracked by the count
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter on the data-memory bus.
// Ports:
//   clock, reset : clock and asynchronous active-high reset
//   address      : bus address; TXDATA at BASE_ADDR, STATUS at BASE_ADDR+4
//   width        : byte-lane enables; lane 0 qualifies a TXDATA store
//   write        : store strobe
//   dataIn       : store data (byte in [7:0], ovf clear in bit 3 for STATUS)
//   dataOut      : combinational read data, STATUS or zero
//   txd          : serial line, idle high, registered
//   busy         : frame in flight or FIFO non-empty, registered
module uart_tx_port
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [31:0] BASE_ADDR    = 32'hf000_0010
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [3:0]  width,
  input  logic        write,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut,
  output logic        txd,
  output logic        busy
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_MAX    = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [31:0]       TXDATA_ADDR = BASE_ADDR + 32'(TXDATA_OFFSET);
  localparam logic [31:0]       STATUS_ADDR = BASE_ADDR + 32'(STATUS_OFFSET);

  tx_state_e            state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [7:0]           shift_q, shift_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic                 ovf_q, ovf_d;

  logic             push_req_c, ovf_clr_c, pop_c;
  logic [7:0]       fifo_head_c;
  logic             fifo_full_c, fifo_empty_c;
  logic [CNT_W-1:0] fifo_count;
  logic             unused_bits_c;

  // Bus decode
  assign push_req_c    = write && (address == TXDATA_ADDR) && width[0];
  assign ovf_clr_c     = write && (address == STATUS_ADDR) && dataIn[STAT_OVF];
  assign unused_bits_c = ^{width[3:1], dataIn[31:8]};

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_req_c),
    .push_data (dataIn[7:0]),
    .pop       (pop_c),
    .head_c    (fifo_head_c),
    .full_c    (fifo_full_c),
    .empty_c   (fifo_empty_c),
    .count     (fifo_count)
  );

  // STATUS read mux; any other address reads zero
  always_comb begin
    dataOut = '0;
    if (address == STATUS_ADDR) begin
      dataOut[STAT_FULL]                   = fifo_full_c;
      dataOut[STAT_EMPTY]                  = fifo_empty_c;
      dataOut[STAT_BUSY]                   = (state_q != ST_IDLE);
      dataOut[STAT_OVF]                    = ovf_q;
      dataOut[STAT_COUNT_HI:STAT_COUNT_LO] = 4'(fifo_count);
    end
  end

  // Transmit FSM; txd_d is the line level for the cycle after the edge
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    pop_c     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        if (!fifo_empty_c) begin
          pop_c   = 1'b1;
          shift_d = fifo_head_c;
          baud_d  = BAUD_MAX;
          state_d = ST_START;
          txd_d   = 1'b0;
        end
      end
      ST_START: begin
        if (baud_q == '0) begin
          state_d   = ST_DATA;
          baud_d    = BAUD_MAX;
          bit_idx_d = '0;
          txd_d     = shift_q[0];
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_MAX;
          if (bit_idx_q == BIT_IDX_W'(7)) begin
            state_d = ST_STOP;
            txd_d   = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
            shift_d   = {1'b0, shift_q[7:1]};
            txd_d     = shift_q[1];
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_q == '0) begin
          // Chain the next frame straight out of the stop bit
          if (!fifo_empty_c) begin
            pop_c   = 1'b1;
            shift_d = fifo_head_c;
            baud_d  = BAUD_MAX;
            state_d = ST_START;
            txd_d   = 1'b0;
          end else begin
            state_d = ST_IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Overflow flag and busy; a dropped push implies a non-empty FIFO
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr_c) ovf_d = 1'b0;
    if (push_req_c && fifo_full_c && !pop_c) ovf_d = 1'b1;
    busy_d = (state_d != ST_IDLE) || !fifo_empty_c || push_req_c;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
    end
  end

  assign txd  = txd_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_port.sv
// Self-checking bench for uart_tx_port: directed scenarios plus random traffic,
// compared every cycle against a frame-timing model built from the bus rules.
module tb_uart_tx_port;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int          FRAME = 10 * CPB;
  localparam logic [31:0] BASE  = 32'hf000_0010;
  localparam logic [31:0] STAT  = 32'hf000_0014;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic [3:0]  width;
  logic        write;
  logic [31:0] dataIn;
  logic [31:0] dataOut;
  logic        txd;
  logic        busy;

  always #5 clock = ~clock;

  uart_tx_port #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .BASE_ADDR    (BASE)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .address (address),
    .width   (width),
    .write   (write),
    .dataIn  (dataIn),
    .dataOut (dataOut),
    .txd     (txd),
    .busy    (busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queued bytes, byte on the wire, time into its frame
  logic [7:0]  mq[$];
  logic [7:0]  cur = 8'h00;
  int          ft = -1;
  logic        movf = 1'b0;
  int          cyc_n = 0;
  int          first_fall = -1;
  logic [31:0] last_do;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s    = '0;
    s[0] = (mq.size() == DEPTH);
    s[1] = (mq.size() == 0);
    s[2] = (ft >= 0);
    s[3] = movf;
    s[7:4] = 4'(mq.size());
    return s;
  endfunction

  // Line level from position inside the 10-bit frame
  function automatic logic exp_txd();
    int b;
    if (ft < 0) return 1'b1;
    b = ft / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return cur[b-1];
    return 1'b1;
  endfunction

  task automatic model_edge(input logic wr, input logic [31:0] a, input logic [3:0] w,
                            input logic [31:0] d);
    bit pop;
    bit full_before;
    pop = 1'b0;
    full_before = (mq.size() == DEPTH);
    if (ft == FRAME - 1) ft = -1;
    else if (ft >= 0) ft++;
    if (ft < 0 && mq.size() > 0) begin
      cur = mq.pop_front();
      ft  = 0;
      pop = 1'b1;
    end
    if (wr && a == BASE && w[0]) begin
      if (!full_before || pop) mq.push_back(d[7:0]);
      else movf = 1'b1;
    end
    if (wr && a == STAT && d[3]) movf = 1'b0;
  endtask

  // One bus cycle: entered and left at posedge+1
  task automatic cyc(input logic wr, input logic [31:0] a, input logic [3:0] w,
                     input logic [31:0] d);
    logic tprev;
    write = wr; address = a; width = w; dataIn = d;
    #3;
    last_do = dataOut;
    check("dataOut", dataOut, (a == STAT) ? model_status() : 32'h0);
    tprev = txd;
    @(posedge clock);
    model_edge(wr, a, w, d);
    cyc_n++;
    #1;
    check("txd", 32'(txd), 32'(exp_txd()));
    check("busy", 32'(busy), 32'((ft >= 0) || (mq.size() > 0)));
    if (tprev === 1'b1 && txd === 1'b0 && first_fall < 0) first_fall = cyc_n;
    write = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic rd_stat();
    cyc(1'b0, STAT, 4'h0, 32'h0);
  endtask

  task automatic wait_idle(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      idle();
      if (busy === 1'b0) begin
        at = cyc_n;
        break;
      end
    end
  endtask

  initial begin
    int ref_n;
    int at;
    int r;

    // Reset state before any clock edge
    reset = 1'b1; write = 1'b0; address = 32'h0; width = 4'h0; dataIn = 32'h0;
    #2;
    check("rst_txd", 32'(txd), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    address = STAT;
    #1;
    check("rst_status", dataOut, 32'h2);
    #10 reset = 1'b0;
    @(posedge clock); #1;

    // Single byte 0x41: fall 2 edges after write, busy 40 cycles after fall
    first_fall = -1;
    cyc(1'b1, BASE, 4'b0001, 32'h1234_5641);
    ref_n = cyc_n;
    wait_idle(100, at);
    check("single_fall_latency", 32'(first_fall - ref_n), 32'd1);
    check("single_busy_len", 32'(at - first_fall), 32'(FRAME));

    // Back-to-back 0x55, 0xAA: contiguous, 80 cycles, count 1 during first frame
    first_fall = -1;
    cyc(1'b1, BASE, 4'b0001, 32'h0000_0055);
    ref_n = cyc_n;
    cyc(1'b1, BASE, 4'b1111, 32'hFFFF_FFAA);
    rd_stat();
    check("b2b_count", 32'(last_do[7:4]), 32'd1);
    wait_idle(200, at);
    check("b2b_fall_latency", 32'(first_fall - ref_n), 32'd1);
    check("b2b_busy_len", 32'(at - first_fall), 32'(2 * FRAME));

    // Overflow: 6 writes, 5 sent, ovf sticky until STATUS write of bit 3
    first_fall = -1;
    for (int i = 0; i < 6; i++) cyc(1'b1, BASE, 4'b0001, 32'($urandom_range(0, 255)));
    rd_stat();
    check("ovf_set", 32'(last_do[3]), 32'h1);
    check("ovf_full", 32'(last_do[0]), 32'h1);
    cyc(1'b1, STAT, 4'hF, 32'h0000_0008);
    rd_stat();
    check("ovf_clear", 32'(last_do[3]), 32'h0);
    wait_idle(400, at);
    check("ovf_busy_len", 32'(at - first_fall), 32'(5 * FRAME));

    // Push while full on the stop-bit pop edge: accepted, no overflow
    first_fall = -1;
    cyc(1'b1, BASE, 4'b0001, 32'h0000_0011);
    ref_n = cyc_n;
    for (int i = 0; i < 4; i++) cyc(1'b1, BASE, 4'b0001, 32'(8'h21 + 8'(i)));
    while (cyc_n < ref_n + FRAME) rd_stat();
    check("pp_full_before", 32'(last_do[0]), 32'h1);
    cyc(1'b1, BASE, 4'b0001, 32'h0000_00C3);
    rd_stat();
    check("pp_count", 32'(last_do[7:4]), 32'd4);
    check("pp_ovf", 32'(last_do[3]), 32'h0);
    wait_idle(400, at);
    check("pp_busy_len", 32'(at - first_fall), 32'(6 * FRAME));

    // Decode: other address and missing lane 0 do not push
    cyc(1'b1, BASE + 32'd8, 4'hF, 32'h0000_0041);
    cyc(1'b1, BASE, 4'b0010, 32'h0000_0041);
    idle();
    rd_stat();
    check("decode_status", last_do, 32'h2);
    check("decode_txd", 32'(txd), 32'h1);

    // Asynchronous reset mid-frame discards frame and FIFO
    cyc(1'b1, BASE, 4'b0001, 32'h0000_0000);
    for (int i = 0; i < 3; i++) cyc(1'b1, BASE, 4'b0001, 32'($urandom_range(0, 255)));
    for (int i = 0; i < 4; i++) idle();
    check("midframe_txd_low", 32'(txd), 32'h0);
    #2 reset = 1'b1;
    #1;
    check("midreset_txd", 32'(txd), 32'h1);
    check("midreset_busy", 32'(busy), 32'h0);
    address = STAT;
    #1;
    check("midreset_status", dataOut, 32'h2);
    mq.delete();
    ft = -1;
    movf = 1'b0;
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;
    idle();

    // Random bus traffic against the model
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 3)       cyc(1'b1, BASE, 4'($urandom), $urandom);
      else if (r == 3) cyc(1'b1, STAT, 4'($urandom), $urandom);
      else if (r == 4) cyc(1'b1, (r[0] ? $urandom : BASE + 32'd8), 4'hF, $urandom);
      else if (r == 5) rd_stat();
      else             idle();
    end
    wait_idle(1000, at);
    check("rand_drain", 32'(at >= 0), 32'h1);
    rd_stat();
    check("rand_final_empty", 32'(last_do[1]), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc_n);
    $fatal(1);
  end

endmodule
